factorial_rr_scheduler: RTL and testbench
=========================================

Name: factorial_rr_scheduler

Overview:
- Sequential round-robin scheduler that shares one iterative factorial engine among NREQ requesters.
- The engine performs one multiply per clock.
- Each requester presents a 4-bit operand and waits for a one-hot done pulse.
- The block replaces per-requester combinational factorial logic in the arithmetic subsystem.

Parameters:
NREQ, 4, number of requesters (2..8)
NW, 4, operand width per requester
OW, 32, result/accumulator width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester, level
num_flat  input  NREQ*NW  operands, requester k at bits [k*NW +: NW]
grant  output  NREQ  one-hot, owner of the engine; 0 when idle
busy  output  1  high in MULT and DONE states
result  output  OW  factorial of granted operand, mod 2^OW
done  output  NREQ  one-hot one-cycle pulse to the owner when result is valid
overflow  output  1  true factorial exceeded OW bits; valid with done

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: grant=0, busy=0, result=0, done=0, overflow=0, state=IDLE, rr pointer=0, acc=0, i=0, n=0.
- States: IDLE, MULT, DONE. All outputs are registered.
- IDLE:
  - If any req is set, choose the first set bit searching upward from the pointer, wrapping modulo NREQ; call it k.
  - At the edge: grant<=onehot(k), n<=operand k, acc<=1, i<=1, state<=MULT.
  - If no req is set, stay in IDLE.
- MULT:
  - Each cycle: acc<=acc*i truncated to OW, i<=i+1.
  - When i>=n, go to DONE. n=0 therefore takes exactly one MULT cycle and gives 1.
  - Number of MULT cycles = max(n,1).
- DONE (one cycle):
  - result=acc, done=grant, overflow=sticky flag.
  - At the edge: pointer<=(k+1) mod NREQ, grant<=0, state<=IDLE.
  - result and overflow hold until the next DONE.
- Latency: done is high max(n,1)+1 cycles after the grant edge. No new grant is issued before the IDLE cycle after DONE, so arbitration gaps are at least 1 cycle.
- Operand n is latched at grant; later changes to num_flat are ignored.
- A requester that drops req mid-operation still receives the done pulse; the operation is never aborted.
- Requests arriving while busy wait; no request is lost while its req is held.
- If a requester still holds req in the cycle after its done, it is treated as a new request. It is served only after the others per round-robin order.
- Asynchronous reset mid-operation: everything returns to reset values immediately, no done is issued, and the pointer returns to 0.
- Arithmetic: the product uses a 2*OW-bit intermediate; the low OW bits go to acc. 12! is the largest value that fits in 32 bits.

Optional Feature:
- Macro FACT_OVF_DETECT_EN.
- Defined:
  - A sticky flag clears at grant.
  - The flag sets in any MULT cycle whose full product has non-zero bits above OW-1.
  - The flag drives overflow in DONE.
- Undefined: no detection logic; overflow is tied to 0. The port always exists.

Test Plan:
- Reset: assert rst_n=0 mid-MULT with n=9 -> all outputs 0 at once; after release with no req, no done ever appears.
- Single request: req=0001, operand 5 -> grant=0001 next edge; done=0001 exactly 6 cycles after the grant edge; result=120; overflow=0.
- Edge operands: operand 0 -> result 1, done 2 cycles after grant; operand 1 -> result 1; operand 12 -> result 479001600, overflow=0.
- Round-robin: req=1111 held continuously, all operands 3 -> grant order 0,1,2,3,0; every result=6; one IDLE cycle between DONE and the next grant.
- Overflow: operand 13 -> result 1932053504. With the macro, overflow=1. Without the macro, overflow=0. A following operand 4 -> result 24, overflow=0.
- Operand hold: requester 2 has operand 4; at grant, change its operand to 7 and drop req -> result 24 and done=0100 are still produced.

Source files
------------

// File: rtl/factorial_rr_scheduler.sv
// Round-robin scheduler sharing one iterative factorial engine (one multiply per clock) among NREQ requesters.
// Optional overflow detection is enabled by defining FACT_OVF_DETECT_EN; otherwise overflow is tied low.
module factorial_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int NW   = 4,
    parameter int OW   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*NW-1:0] num_flat,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [OW-1:0]      result,
    output logic [NREQ-1:0]    done,
    output logic               overflow
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t            state, state_d;
    logic [PW-1:0]     ptr, ptr_d;
    logic [PW-1:0]     owner, owner_d;
    logic [PW-1:0]     pick;
    logic              pick_vld;
    logic [NW-1:0]     n, n_d;
    logic [NW:0]       i, i_d;
    logic [OW-1:0]     acc, acc_d;
    logic [NREQ-1:0]   grant_d;
    logic [NREQ-1:0]   done_d;
    logic [OW-1:0]     result_d;
    logic              busy_d;

    // Low OW bits of the 2*OW-bit product; this is all the accumulator keeps.
    function automatic logic [OW-1:0] mul_lo(input logic [OW-1:0] a, input logic [NW:0] b);
        return OW'({{OW{1'b0}}, a} * {{(2*OW-NW-1){1'b0}}, b});
    endfunction

`ifdef FACT_OVF_DETECT_EN
    logic ovf_flag, ovf_flag_d;
    logic overflow_d;

    function automatic logic mul_hi_nz(input logic [OW-1:0] a, input logic [NW:0] b);
        logic [2*OW-1:0] full;
        full = {{OW{1'b0}}, a} * {{(2*OW-NW-1){1'b0}}, b};
        return |full[2*OW-1:OW];
    endfunction
`else
    assign overflow = 1'b0;
`endif

    // First pending requester at or above the pointer, wrapping; lowest offset wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[(int'(ptr) + j) % NREQ]) begin
                pick     = PW'((int'(ptr) + j) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_vld) state_d = MULT;
            MULT:    if (i >= {1'b0, n}) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr;
        owner_d  = owner;
        n_d      = n;
        i_d      = i;
        acc_d    = acc;
        grant_d  = grant;
        done_d   = '0;
        result_d = result;
`ifdef FACT_OVF_DETECT_EN
        ovf_flag_d = ovf_flag;
        overflow_d = overflow;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = NREQ'(1) << pick;
                    owner_d = pick;
                    n_d     = num_flat[int'(pick)*NW +: NW];
                    acc_d   = OW'(1);
                    i_d     = (NW+1)'(1);
`ifdef FACT_OVF_DETECT_EN
                    ovf_flag_d = 1'b0;
`endif
                end
            end
            MULT: begin
                acc_d = mul_lo(acc, i);
                i_d   = i + 1'b1;
`ifdef FACT_OVF_DETECT_EN
                if (mul_hi_nz(acc, i)) ovf_flag_d = 1'b1;
`endif
            end
            DONE: begin
                result_d = acc;
                done_d   = grant;
                grant_d  = '0;
                ptr_d    = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
`ifdef FACT_OVF_DETECT_EN
                overflow_d = ovf_flag;
`endif
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            owner  <= '0;
            n      <= '0;
            i      <= '0;
            acc    <= '0;
            grant  <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
        end else begin
            ptr    <= ptr_d;
            owner  <= owner_d;
            n      <= n_d;
            i      <= i_d;
            acc    <= acc_d;
            grant  <= grant_d;
            done   <= done_d;
            result <= result_d;
            busy   <= busy_d;
        end
    end

`ifdef FACT_OVF_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ovf_flag <= ovf_flag_d;
            overflow <= overflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_factorial_rr_scheduler.sv
// Bench for factorial_rr_scheduler: directed table, reset/round-robin/operand-hold sequences, random traffic vs model.
module tb_factorial_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] num_flat;
    logic [3:0]  grant;
    logic        busy;
    logic [31:0] result;
    logic [3:0]  done;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

`ifdef FACT_OVF_DETECT_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    factorial_rr_scheduler #(.NREQ(4), .NW(4), .OW(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .num_flat(num_flat),
        .grant(grant), .busy(busy), .result(result), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] nums;
        logic [3:0]  eg;
        logic [31:0] er;
        int          el;
        logic        eo;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Exact factorial; operands are at most 15 so 64 bits hold it.
    function automatic logic [63:0] fact(input int n);
        logic [63:0] f = 64'd1;
        for (int m = 2; m <= n; m++) f = f * 64'(m);
        return f;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) if (r[(p + j) % 4]) return (p + j) % 4;
        return -1;
    endfunction

    // One transaction: present r/nums in an IDLE cycle, then switch inputs to r_after/nums_after after the grant.
    task automatic txn(input string nm, input logic [3:0] r, input logic [15:0] nums,
                       input logic [3:0] r_after, input logic [15:0] nums_after,
                       input logic [3:0] eg, input logic [31:0] er, input int el, input logic eo);
        int gw, cnt;
        bit got;
        req = r;
        num_flat = nums;
        got = 0;
        gw = 0;
        while (!got && gw < 40) begin
            @(posedge clk); #1;
            gw++;
            if (grant != 0) got = 1;
        end
        chk({nm, ".grant"}, grant, eg);
        chk({nm, ".grant_wait"}, gw, 1);
        if (!got) begin
            req = '0;
            return;
        end
        chk({nm, ".busy"}, busy, 1);
        req = r_after;
        num_flat = nums_after;
        got = 0;
        cnt = 0;
        while (!got && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            if (done != 0) got = 1;
        end
        chk({nm, ".latency"}, cnt, el);
        chk({nm, ".done"}, done, eg);
        chk({nm, ".result"}, result, er);
        chk({nm, ".overflow"}, overflow, eo);
        chk({nm, ".grant_gap"}, grant, 0);
        chk({nm, ".busy_idle"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int mptr, k, n, dones;
        logic [3:0]  r, rn;
        logic [15:0] nums, nn;
        logic [63:0] f;

        tbl[0] = '{4'b0001, 16'h0005, 4'b0001, 32'd120,        6,  1'b0};
        tbl[1] = '{4'b0001, 16'h0000, 4'b0001, 32'd1,          2,  1'b0};
        tbl[2] = '{4'b0010, 16'h0010, 4'b0010, 32'd1,          2,  1'b0};
        tbl[3] = '{4'b1000, 16'hC000, 4'b1000, 32'd479001600,  13, 1'b0};
        tbl[4] = '{4'b0100, 16'h0D00, 4'b0100, 32'd1932053504, 14, OVF_ON};
        tbl[5] = '{4'b0001, 16'h0004, 4'b0001, 32'd24,         5,  1'b0};
        tbl[6] = '{4'b1111, 16'h3333, 4'b0010, 32'd6,          4,  1'b0};
        tbl[7] = '{4'b1010, 16'h2222, 4'b1000, 32'd2,          3,  1'b0};

        rst_n = 1'b0;
        req = '0;
        num_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.grant", grant, 0);
        chk("reset.busy", busy, 0);
        chk("reset.result", result, 0);
        chk("reset.done", done, 0);
        chk("reset.overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++)
            txn($sformatf("tbl%0d", t), tbl[t].r, tbl[t].nums, 4'b0000, 16'($urandom),
                tbl[t].eg, tbl[t].er, tbl[t].el, tbl[t].eo);

        // Reset in the middle of a 9! computation.
        req = 4'b0001;
        num_flat = 16'h0009;
        @(posedge clk); #1;
        chk("rst_mid.grant", grant, 4'b0001);
        req = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.grant0", grant, 0);
        chk("rst_mid.busy0", busy, 0);
        chk("rst_mid.result0", result, 0);
        chk("rst_mid.done0", done, 0);
        chk("rst_mid.overflow0", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done != 0 || busy) dones++;
        end
        chk("rst_mid.no_done_after", dones, 0);

        // All four requesting continuously: 0,1,2,3,0 from a freshly reset pointer.
        for (int s = 0; s < 5; s++)
            txn($sformatf("rr%0d", s), 4'b1111, 16'h3333, 4'b1111, 16'h3333,
                4'b0001 << (s % 4), 32'd6, 4, 1'b0);

        // Operand changed and request dropped right after the grant.
        txn("hold", 4'b0100, 16'h0400, 4'b0000, 16'h0700, 4'b0100, 32'd24, 5, 1'b0);
        mptr = 3;

        r = 4'($urandom_range(1, 15));
        nums = 16'($urandom);
        for (int t = 0; t < 40; t++) begin
            rn = 4'($urandom_range(1, 15));
            nn = 16'($urandom);
            k = rr_pick(r, mptr);
            n = int'(nums[k*4 +: 4]);
            f = fact(n);
            txn($sformatf("rnd%0d", t), r, nums, rn, nn, 4'b0001 << k, f[31:0],
                (n < 1 ? 1 : n) + 1, OVF_ON && (f > 64'hFFFF_FFFF));
            mptr = (k + 1) % 4;
            r = rn;
            nums = nn;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
